// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   - state encoding (ST_* localparams and the matching typed enum)
//   - cnt_width(): width of the bit counter for a given operand width
package serial_subtractor_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT,
    StDone  = ST_DONE
  } state_e;

  // Counter only has to reach width-1; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus between a controller and the
// bit-serial subtractor.
//   start, a, b, bin : request and operands (controller -> subtractor)
//   busy, done       : status (subtractor -> controller)
//   diff, borrow     : result, valid while done is high and held until the next accept
// master = controller side, slave = subtractor side.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, borrow
  );
endinterface

// File: rtl/fa_cell.sv
// Single combinational full-adder cell.
//   a_i, b_i, cin_i : addend bits and carry-in
//   sum_o           : a ^ b ^ cin
//   cout_o          : majority(a, b, cin)
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), borrow = (a < b + bin).
// Computes a + ~b + ~bin LSB first through one full-adder cell, one bit per clock.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, overrides everything
//   bus : slave side of serial_subtractor_if (start/a/b/bin in, busy/done/diff/borrow out)
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             sum, cout;
  logic             last;

  fa_cell u_fa (
    .a_i   (a_q[0]),
    .b_i   (~b_q[0]),
    .cin_i (carry_q),
    .sum_o (sum),
    .cout_o(cout)
  );

  assign last = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = ~bus.bin;
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        // a_q doubles as the partial-sum register: sum bits enter at the MSB while
        // operand bits leave at the LSB, so after WIDTH shifts it holds the result.
        a_d     = {sum, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = cout;
        cnt_d   = cnt_q + CntW'(1);
        if (last) begin
          diff_d   = {sum, a_q[WIDTH-1:1]};
          borrow_d = ~cout;
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign bus.busy   = (state_q == StShift);
  assign bus.done   = (state_q == StDone);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

endmodule
